// File: rtl/scoreboard_write_arbiter.sv
// Write-result arbiter for the scoreboard: picks at most one finished FU per cycle, honours the
// WAR condition from the FU status table and drives the single register-file write port.
module scoreboard_write_arbiter #(
  parameter int unsigned NUM_FUS    = 4,
  parameter int unsigned FU_BITS    = 2,
  parameter int unsigned REG_BITS   = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_FUS-1:0]             req_valid,
  input  logic [NUM_FUS*REG_BITS-1:0]    req_reg,
  input  logic [NUM_FUS*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_FUS-1:0]             fu_busy,
  input  logic [NUM_FUS*REG_BITS-1:0]    fu_fj,
  input  logic [NUM_FUS*REG_BITS-1:0]    fu_fk,
  input  logic [NUM_FUS-1:0]             fu_rj,
  input  logic [NUM_FUS-1:0]             fu_rk,
  output logic [NUM_FUS-1:0]             grant,
  output logic                           rf_we,
  output logic [REG_BITS-1:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0]          rf_wdata,
  output logic [NUM_FUS-1:0]             war_stall,
  output logic                           starved
);

  localparam int unsigned CntBits = $clog2(MAX_WAIT + 1);
  localparam logic [CntBits-1:0] CntMax = CntBits'(MAX_WAIT);

  logic [NUM_FUS-1:0]    grant_q;
  logic                  rf_we_q;
  logic [REG_BITS-1:0]   rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic                  starved_q, starved_d;
  logic [FU_BITS-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CntBits-1:0]    wait_cnt_q [NUM_FUS];
  logic [CntBits-1:0]    wait_cnt_d [NUM_FUS];

  logic [NUM_FUS-1:0]    war_hit;
  logic [NUM_FUS-1:0]    eligible;
  logic                  win_valid;
  logic [FU_BITS-1:0]    win_idx;
  logic [NUM_FUS-1:0]    win_onehot;
  logic [FU_BITS-1:0]    scan_idx;

  // A pending reader of our destination register in any other FU blocks the write.
  always_comb begin
    war_hit = '0;
    for (int i = 0; i < NUM_FUS; i++) begin
      for (int f = 0; f < NUM_FUS; f++) begin
        if (f != i && fu_busy[f] &&
            ((fu_fj[f*REG_BITS +: REG_BITS] == req_reg[i*REG_BITS +: REG_BITS] && fu_rj[f]) ||
             (fu_fk[f*REG_BITS +: REG_BITS] == req_reg[i*REG_BITS +: REG_BITS] && fu_rk[f]))) begin
          war_hit[i] = 1'b1;
        end
      end
    end
  end

  assign war_stall = req_valid & war_hit;
  // Masking the last grantee avoids a double grant while its request is still dropping.
  assign eligible  = req_valid & ~war_stall & ~grant_q;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_FUS; i++) begin
      if (!win_valid && eligible[i] && wait_cnt_q[i] == CntMax) begin
        win_valid = 1'b1;
        win_idx   = FU_BITS'(i);
      end
    end
    for (int unsigned k = 0; k < NUM_FUS; k++) begin
      scan_idx = FU_BITS'((32'(rr_ptr_q) + k) % NUM_FUS);
      if (!win_valid && eligible[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign win_onehot = win_valid ? (NUM_FUS'(1) << win_idx) : '0;
  assign rr_ptr_d   = win_valid ? FU_BITS'((32'(win_idx) + 1) % NUM_FUS) : rr_ptr_q;

  always_comb begin
    starved_d = 1'b0;
    for (int i = 0; i < NUM_FUS; i++) begin
      if (!req_valid[i] || (win_valid && win_idx == FU_BITS'(i))) begin
        wait_cnt_d[i] = '0;
      end else if (wait_cnt_q[i] != CntMax) begin
        wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
      end else begin
        wait_cnt_d[i] = wait_cnt_q[i];
      end
      if (wait_cnt_d[i] == CntMax) begin
        starved_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      grant_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      starved_q  <= 1'b0;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '{default: '0};
    end else begin
      grant_q    <= win_onehot;
      rf_we_q    <= win_valid;
      if (win_valid) begin
        rf_waddr_q <= req_reg[win_idx*REG_BITS +: REG_BITS];
        rf_wdata_q <= req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
      end
      starved_q  <= starved_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign grant    = grant_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign starved  = starved_q;

endmodule

// File: tb/tb_scoreboard_write_arbiter.sv
// Directed bench for scoreboard_write_arbiter: stimulus queues expected writes, a monitor
// checks every register-file write against the queue.
module tb_scoreboard_write_arbiter;

  logic         clk = 1'b0;
  logic         rst, flush;
  logic [3:0]   req_valid;
  logic [19:0]  req_reg;
  logic [127:0] req_data;
  logic [3:0]   fu_busy;
  logic [19:0]  fu_fj, fu_fk;
  logic [3:0]   fu_rj, fu_rk;
  logic [3:0]   grant;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [3:0]   war_stall;
  logic         starved;

  typedef struct {
    int          cyc;
    logic [3:0]  grant;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scoreboard_write_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .fu_busy   (fu_busy),
    .fu_fj     (fu_fj),
    .fu_fk     (fu_fk),
    .fu_rj     (fu_rj),
    .fu_rk     (fu_rk),
    .grant     (grant),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .war_stall (war_stall),
    .starved   (starved)
  );

  // Monitor: invariants every cycle, and each write popped against the expected queue.
  always @(posedge clk) begin
    #1;
    checks++;
    if ($countones(grant) > 1 || rf_we !== (|grant)) begin
      errors++;
      $display("FAIL grant_onehot cyc=%0d: grant=%b rf_we=%b", cyc, grant, rf_we);
    end
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d: grant=%b addr=%0d data=%h", cyc, grant,
                 rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || grant !== e.grant || rf_waddr !== e.addr || rf_wdata !== e.data) begin
          errors++;
          $display("FAIL write: got cyc=%0d grant=%b addr=%0d data=%h, expected cyc=%0d grant=%b addr=%0d data=%h",
                   cyc, grant, rf_waddr, rf_wdata, e.cyc, e.grant, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input int fu, input logic [4:0] addr, input logic [31:0] data);
    exp_t x;
    x.cyc   = c;
    x.grant = 4'b0001 << fu;
    x.addr  = addr;
    x.data  = data;
    exp_q.push_back(x);
  endtask

  task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
    req_reg[i*5 +: 5]   = r;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic clear_status();
    fu_busy = '0;
    fu_fj   = '0;
    fu_fk   = '0;
    fu_rj   = '0;
    fu_rk   = '0;
  endtask

  task automatic do_flush();
    flush     = 1'b1;
    req_valid = '0;
    clear_status();
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    req_reg  = '0;
    req_data = '0;
    clear_status();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_req(i, 5'(10 + i), 32'h1000_0000 + 32'(i));

    // Reset held two cycles with all requests pending.
    tick();
    chk("reset_grant", 64'(grant), 64'h0);
    chk("reset_rf_we", 64'(rf_we), 64'h0);
    chk("reset_waddr", 64'(rf_waddr), 64'h0);
    chk("reset_wdata", 64'(rf_wdata), 64'h0);
    chk("reset_starved", 64'(starved), 64'h0);
    tick();
    chk("reset_grant2", 64'(grant), 64'h0);
    chk("reset_rf_we2", 64'(rf_we), 64'h0);
    rst = 1'b0;

    // Round-robin over all four, wrapping back to FU0.
    for (int k = 0; k < 5; k++) push(cyc + 1 + k, k % 4, 5'(10 + k % 4), 32'h1000_0000 + 32'(k % 4));
    repeat (5) tick();
    req_valid = '0;

    // WAR: FU2 writes r7 while FU0 still needs to read r7 as Fj.
    do_flush();
    req_valid = 4'b0100;
    set_req(2, 5'd7, 32'h2222_0007);
    fu_busy = 4'b0001;
    fu_fj[4:0] = 5'd7;
    fu_rj = 4'b0001;
    #1;
    chk("war_stall_set", 64'(war_stall), 64'h4);
    repeat (4) tick();
    chk("war_stall_held", 64'(war_stall), 64'h4);
    fu_rj = 4'b0000;
    #1;
    chk("war_stall_clear", 64'(war_stall), 64'h0);
    push(cyc + 1, 2, 5'd7, 32'h2222_0007);
    tick();
    tick();
    req_valid = '0;

    // Data path, with FU1's own status entry reading r12 (must not block itself).
    do_flush();
    req_valid = 4'b0010;
    set_req(1, 5'd12, 32'hDEAD_BEEF);
    fu_busy = 4'b0010;
    fu_fj[9:5] = 5'd12;
    fu_rj = 4'b0010;
    #1;
    chk("war_self_entry", 64'(war_stall), 64'h0);
    push(cyc + 1, 1, 5'd12, 32'hDEAD_BEEF);
    tick();
    req_valid = '0;
    set_req(1, 5'd12, 32'h0);
    tick();
    chk("data_we_low", 64'(rf_we), 64'h0);
    chk("data_waddr_hold", 64'(rf_waddr), 64'd12);
    chk("data_wdata_hold", 64'(rf_wdata), 64'hDEAD_BEEF);

    // Starvation: FU3 (r20) blocked by FU2's Fk while FU0/FU1 alternate.
    do_flush();
    req_valid = 4'b1011;
    set_req(0, 5'd1, 32'hA000_0000);
    set_req(1, 5'd2, 32'hA000_0001);
    set_req(3, 5'd20, 32'hA000_0003);
    fu_busy = 4'b0100;
    fu_fk[14:10] = 5'd20;
    fu_rk = 4'b0100;
    #1;
    chk("war_stall_fk", 64'(war_stall), 64'h8);
    for (int k = 1; k <= 7; k++) begin
      if (k % 2 == 1) push(cyc + k, 0, 5'd1, 32'hA000_0000);
      else push(cyc + k, 1, 5'd2, 32'hA000_0001);
    end
    repeat (6) tick();
    chk("starved_before_sat", 64'(starved), 64'h0);
    tick();
    chk("starved_at_sat", 64'(starved), 64'h1);
    // rr_ptr now points at FU1; the saturated FU3 must pre-empt it.
    fu_rk = 4'b0000;
    push(cyc + 1, 3, 5'd20, 32'hA000_0003);
    push(cyc + 2, 0, 5'd1, 32'hA000_0000);
    tick();
    chk("starved_cleared", 64'(starved), 64'h0);
    req_valid = 4'b0011;
    tick();

    // Flush with all four pending: the pending decision is discarded.
    set_req(2, 5'd3, 32'hA000_0002);
    req_valid = 4'b1111;
    fu_busy = '0;
    flush = 1'b1;
    tick();
    chk("flush_grant", 64'(grant), 64'h0);
    chk("flush_rf_we", 64'(rf_we), 64'h0);
    chk("flush_waddr", 64'(rf_waddr), 64'h0);
    chk("flush_wdata", 64'(rf_wdata), 64'h0);
    chk("flush_starved", 64'(starved), 64'h0);
    flush = 1'b0;
    push(cyc + 1, 0, 5'd1, 32'hA000_0000);
    push(cyc + 2, 1, 5'd2, 32'hA000_0001);
    tick();
    tick();
    req_valid = '0;
    repeat (3) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: %0d expected writes never seen, first due cyc=%0d",
               exp_q.size(), exp_q[0].cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
